// File: rtl/axi2core_mem_if.sv
// Channel bundle for axi2core_mem: AXI4 slave side plus the core-style memory port.
// The slave modport is the bridge's view; master is the view of whoever drives AXI and serves memory.
interface axi2core_mem_if #(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_ID_WIDTH      = 16
);
    localparam int AW = AXI4_ADDRESS_WIDTH;
    localparam int IW = AXI4_ID_WIDTH;

    logic [IW-1:0] aw_id_i;
    logic [AW-1:0] aw_addr_i;
    logic [7:0]    aw_len_i;
    logic [1:0]    aw_burst_i;
    logic          aw_valid_i;
    logic          aw_ready_o;

    logic [31:0]   w_data_i;
    logic [3:0]    w_strb_i;
    logic          w_last_i;
    logic          w_valid_i;
    logic          w_ready_o;

    logic [IW-1:0] b_id_o;
    logic [1:0]    b_resp_o;
    logic          b_valid_o;
    logic          b_ready_i;

    logic [IW-1:0] ar_id_i;
    logic [AW-1:0] ar_addr_i;
    logic [7:0]    ar_len_i;
    logic [1:0]    ar_burst_i;
    logic          ar_valid_i;
    logic          ar_ready_o;

    logic [IW-1:0] r_id_o;
    logic [31:0]   r_data_o;
    logic [1:0]    r_resp_o;
    logic          r_last_o;
    logic          r_valid_o;
    logic          r_ready_i;

    logic          mem_req_o;
    logic          mem_gnt_i;
    logic [AW-1:0] mem_addr_o;
    logic          mem_we_o;
    logic [3:0]    mem_be_o;
    logic [31:0]   mem_wdata_o;
    logic          mem_rvalid_i;
    logic [31:0]   mem_rdata_i;

    modport slave (
        input  aw_id_i, aw_addr_i, aw_len_i, aw_burst_i, aw_valid_i,
        output aw_ready_o,
        input  w_data_i, w_strb_i, w_last_i, w_valid_i,
        output w_ready_o,
        output b_id_o, b_resp_o, b_valid_o,
        input  b_ready_i,
        input  ar_id_i, ar_addr_i, ar_len_i, ar_burst_i, ar_valid_i,
        output ar_ready_o,
        output r_id_o, r_data_o, r_resp_o, r_last_o, r_valid_o,
        input  r_ready_i,
        output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport master (
        output aw_id_i, aw_addr_i, aw_len_i, aw_burst_i, aw_valid_i,
        input  aw_ready_o,
        output w_data_i, w_strb_i, w_last_i, w_valid_i,
        input  w_ready_o,
        input  b_id_o, b_resp_o, b_valid_o,
        output b_ready_i,
        output ar_id_i, ar_addr_i, ar_len_i, ar_burst_i, ar_valid_i,
        input  ar_ready_o,
        input  r_id_o, r_data_o, r_resp_o, r_last_o, r_valid_o,
        output r_ready_i,
        input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/axi2core_mem.sv
// AXI4 slave to core-style req/gnt/rvalid memory port; one AXI transaction and one
// memory request in flight, single-beat and INCR/FIXED bursts of 32-bit words.
//
// state   | meaning
// IDLE    | no transaction; arbitrate AW vs AR round-robin
// WR_REQ  | memory write request driven straight from the W channel
// WR_ACK  | write granted, waiting for memory rvalid
// WR_RESP | B response held until b_ready
// RD_REQ  | memory read request held until gnt
// RD_ACK  | read granted, waiting for memory rvalid
// RD_DATA | R beat held until r_ready
module axi2core_mem #(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_ID_WIDTH      = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    axi2core_mem_if.slave bus
);
    localparam int AW = AXI4_ADDRESS_WIDTH;
    localparam int IW = AXI4_ID_WIDTH;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_ACK,
        WR_RESP,
        RD_REQ,
        RD_ACK,
        RD_DATA
    } state_e;

    typedef enum logic {
        SEL_READ,
        SEL_WRITE
    } sel_e;

    state_e        state_q, state_d;
    sel_e          last_sel_q, last_sel_d;
    logic [IW-1:0] id_q, id_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    len_q, len_d;
    logic [1:0]    burst_q, burst_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          beat_last;
    logic [AW-1:0] addr_next;

    assign beat_last = (cnt_q == len_q);
    // FIXED stays put; INCR and any other code step by one word and wrap freely.
    assign addr_next = (burst_q == BURST_FIXED) ? addr_q : addr_q + AW'(4);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            last_sel_q <= SEL_READ;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            burst_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_sel_q <= last_sel_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            burst_q    <= burst_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_sel_d = last_sel_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        burst_d    = burst_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        rdata_d    = rdata_q;

        bus.aw_ready_o  = 1'b0;
        bus.ar_ready_o  = 1'b0;
        bus.w_ready_o   = 1'b0;
        bus.b_valid_o   = 1'b0;
        bus.r_valid_o   = 1'b0;
        bus.mem_req_o   = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_be_o    = 4'h0;
        bus.mem_wdata_o = 32'h0;

        unique case (state_q)
            IDLE: begin
                // On contention the side not served last wins, so a ready never pairs with the other.
                if (bus.aw_valid_i && (!bus.ar_valid_i || last_sel_q == SEL_READ)) begin
                    bus.aw_ready_o = 1'b1;
                    id_d           = bus.aw_id_i;
                    addr_d         = bus.aw_addr_i;
                    len_d          = bus.aw_len_i;
                    burst_d        = bus.aw_burst_i;
                    cnt_d          = '0;
                    err_d          = 1'b0;
                    last_sel_d     = SEL_WRITE;
                    state_d        = WR_REQ;
                end else if (bus.ar_valid_i) begin
                    bus.ar_ready_o = 1'b1;
                    id_d           = bus.ar_id_i;
                    addr_d         = bus.ar_addr_i;
                    len_d          = bus.ar_len_i;
                    burst_d        = bus.ar_burst_i;
                    cnt_d          = '0;
                    err_d          = 1'b0;
                    last_sel_d     = SEL_READ;
                    state_d        = RD_REQ;
                end
            end
            WR_REQ: begin
                bus.mem_req_o   = bus.w_valid_i;
                bus.mem_we_o    = 1'b1;
                bus.mem_be_o    = bus.w_strb_i;
                bus.mem_wdata_o = bus.w_data_i;
                bus.w_ready_o   = bus.mem_gnt_i & bus.w_valid_i;
                if (bus.mem_gnt_i && bus.w_valid_i) begin
                    // The burst length comes from aw_len alone; a misplaced w_last only taints the response.
                    if (bus.w_last_i != beat_last) begin
                        err_d = 1'b1;
                    end
                    state_d = WR_ACK;
                end
            end
            WR_ACK: begin
                if (bus.mem_rvalid_i) begin
                    if (beat_last) begin
                        state_d = WR_RESP;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        addr_d  = addr_next;
                        state_d = WR_REQ;
                    end
                end
            end
            WR_RESP: begin
                bus.b_valid_o = 1'b1;
                if (bus.b_ready_i) begin
                    state_d = IDLE;
                end
            end
            RD_REQ: begin
                bus.mem_req_o = 1'b1;
                bus.mem_be_o  = 4'hF;
                if (bus.mem_gnt_i) begin
                    state_d = RD_ACK;
                end
            end
            RD_ACK: begin
                if (bus.mem_rvalid_i) begin
                    rdata_d = bus.mem_rdata_i;
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                bus.r_valid_o = 1'b1;
                if (bus.r_ready_i) begin
                    if (beat_last) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        addr_d  = addr_next;
                        state_d = RD_REQ;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_addr_o = addr_q;
    assign bus.b_id_o     = id_q;
    assign bus.b_resp_o   = err_q ? RESP_SLVERR : RESP_OKAY;
    assign bus.r_id_o     = id_q;
    assign bus.r_data_o   = rdata_q;
    assign bus.r_resp_o   = RESP_OKAY;
    assign bus.r_last_o   = (state_q == RD_DATA) && beat_last;

endmodule
